// File: rtl/fwd_operand_mux.sv
// EX-stage operand forwarding mux: picks one of NUM_SRC sources, holds the
// selected operand across stalls, and optionally registers the result.
module fwd_operand_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int REG_OUT = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         select,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                     stall,
  input  logic                     flush,
  output logic [WIDTH-1:0]         data_out,
  output logic                     held
);

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] live;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] comb_out;
  logic             comb_held;

  // Out-of-range select falls back to source 0 so the operand is never X.
  always_comb begin
    live = data_in[WIDTH-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (int'(select) == k) begin
        live = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over stall from either state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_LIVE;
    end else begin
      case (state_q)
        ST_LIVE: if (stall)  state_d = ST_HOLD;
        ST_HOLD: if (!stall) state_d = ST_LIVE;
        default:             state_d = ST_LIVE;
      endcase
    end
  end

  // Capture only on the edge that enters HOLD; later stall edges keep it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (flush) begin
      hold_q <= '0;
    end else if (state_q == ST_LIVE && stall) begin
      hold_q <= live;
    end
  end

  always_comb begin
    comb_out  = live;
    comb_held = 1'b0;
    if (state_q == ST_HOLD) begin
      comb_out  = hold_q;
      comb_held = 1'b1;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] out_q;
      logic             held_q;

      // Delay data and held together so they stay aligned.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          out_q  <= '0;
          held_q <= 1'b0;
        end else if (flush) begin
          out_q  <= '0;
          held_q <= 1'b0;
        end else begin
          out_q  <= comb_out;
          held_q <= comb_held;
        end
      end

      assign data_out = out_q;
      assign held     = held_q;
    end else begin : g_comb_out
      assign data_out = comb_out;
      assign held     = comb_held;
    end
  endgenerate

endmodule

// File: tb/tb_fwd_operand_mux.sv
// Testbench for fwd_operand_mux: directed scenarios on two configurations plus
// a randomised sweep of four configurations against a behavioural model.
module tb_fwd_operand_mux;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  // Directed instance A: NUM_SRC=3, combinational output
  logic [1:0]  a_sel;
  logic [95:0] a_din;
  logic        a_stall, a_flush, a_held;
  logic [31:0] a_out;

  fwd_operand_mux #(.WIDTH(32), .NUM_SRC(3), .REG_OUT(0)) u_a (
    .clock(clock), .reset_n(reset_n), .select(a_sel), .data_in(a_din),
    .stall(a_stall), .flush(a_flush), .data_out(a_out), .held(a_held)
  );

  // Directed instance B: NUM_SRC=4, registered output
  logic [1:0]   b_sel;
  logic [127:0] b_din;
  logic         b_stall, b_flush, b_held;
  logic [31:0]  b_out;

  fwd_operand_mux #(.WIDTH(32), .NUM_SRC(4), .REG_OUT(1)) u_b (
    .clock(clock), .reset_n(reset_n), .select(b_sel), .data_in(b_din),
    .stall(b_stall), .flush(b_flush), .data_out(b_out), .held(b_held)
  );

  // Random sweep instances share one stimulus bus
  logic [3:0]   r_sel;
  logic [511:0] r_din;
  logic         r_stall, r_flush;
  logic [7:0]   r0_out, r2_out;
  logic [31:0]  r1_out, r3_out;
  logic         r0_held, r1_held, r2_held, r3_held;
  logic [31:0]  r_out  [4];
  logic         r_held [4];

  fwd_operand_mux #(.WIDTH(8), .NUM_SRC(2), .REG_OUT(0)) u_r0 (
    .clock(clock), .reset_n(reset_n), .select(r_sel[0:0]), .data_in(r_din[15:0]),
    .stall(r_stall), .flush(r_flush), .data_out(r0_out), .held(r0_held)
  );
  fwd_operand_mux #(.WIDTH(32), .NUM_SRC(3), .REG_OUT(1)) u_r1 (
    .clock(clock), .reset_n(reset_n), .select(r_sel[1:0]), .data_in(r_din[95:0]),
    .stall(r_stall), .flush(r_flush), .data_out(r1_out), .held(r1_held)
  );
  fwd_operand_mux #(.WIDTH(8), .NUM_SRC(5), .REG_OUT(0)) u_r2 (
    .clock(clock), .reset_n(reset_n), .select(r_sel[2:0]), .data_in(r_din[39:0]),
    .stall(r_stall), .flush(r_flush), .data_out(r2_out), .held(r2_held)
  );
  fwd_operand_mux #(.WIDTH(32), .NUM_SRC(16), .REG_OUT(1)) u_r3 (
    .clock(clock), .reset_n(reset_n), .select(r_sel[3:0]), .data_in(r_din[511:0]),
    .stall(r_stall), .flush(r_flush), .data_out(r3_out), .held(r3_held)
  );

  assign r_out[0]  = {24'd0, r0_out};
  assign r_out[1]  = r1_out;
  assign r_out[2]  = {24'd0, r2_out};
  assign r_out[3]  = r3_out;
  assign r_held[0] = r0_held;
  assign r_held[1] = r1_held;
  assign r_held[2] = r2_held;
  assign r_held[3] = r3_held;

  function automatic int cfg_n(int i);
    case (i) 0: return 2; 1: return 3; 2: return 5; default: return 16; endcase
  endfunction
  function automatic int cfg_w(int i);
    case (i) 0: return 8; 1: return 32; 2: return 8; default: return 32; endcase
  endfunction
  function automatic int cfg_sw(int i);
    case (i) 0: return 1; 1: return 2; 2: return 3; default: return 4; endcase
  endfunction
  function automatic bit cfg_reg(int i);
    return (i == 1 || i == 3);
  endfunction

  // Reference live value: the selected source, or source 0 when out of range
  function automatic logic [31:0] ref_live(int i, logic [3:0] s, logic [511:0] d);
    int           sel;
    logic [511:0] sh;
    logic [31:0]  v;
    sel = int'(s) & ((1 << cfg_sw(i)) - 1);
    if (sel >= cfg_n(i)) sel = 0;
    sh = d >> (sel * cfg_w(i));
    v  = sh[31:0];
    if (cfg_w(i) == 8) v = {24'd0, v[7:0]};
    return v;
  endfunction

  // Model state: whether an operand is held, the held value, and the output stage
  logic        m_hold  [4];
  logic [31:0] m_cap   [4];
  logic [31:0] m_rout  [4];
  logic        m_rheld [4];

  task automatic test_reset();
    reset_n = 1'b1;
    a_din = {32'h33333333, 32'h22222222, 32'h11111111};
    a_sel = 2'd1; a_stall = 1'b0; a_flush = 1'b0;
    b_sel = 2'd0; b_din = '0; b_stall = 1'b0; b_flush = 1'b0;
    r_sel = '0; r_din = '0; r_stall = 1'b0; r_flush = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (a_held !== 1'b0) begin failures++; $display("[TB] FAIL reset_held: got %b want 0", a_held); end
    checks++; if (a_out !== 32'h22222222) begin failures++; $display("[TB] FAIL reset_sel1: got %h want 22222222", a_out); end
    checks++; if (b_out !== 32'h0 || b_held !== 1'b0) begin failures++; $display("[TB] FAIL reset_regout: got %h/%b want 0/0", b_out, b_held); end
    a_sel = 2'd3;
    #1;
    checks++; if (a_out !== 32'h11111111) begin failures++; $display("[TB] FAIL reset_sel_oor: got %h want 11111111", a_out); end
    @(posedge clock); #1;
    checks++; if (b_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_clocked_regout: got %h want 0", b_out); end
    reset_n = 1'b1;
    // Out-of-range select captured into HOLD still yields source 0
    a_stall = 1'b1;
    @(posedge clock); #1;
    a_stall = 1'b0;
    #2;
    checks++; if (a_out !== 32'h11111111 || a_held !== 1'b1) begin failures++; $display("[TB] FAIL oor_hold: got %h/%b want 11111111/1", a_out, a_held); end
    @(posedge clock); #1;
    checks++; if (a_held !== 1'b0) begin failures++; $display("[TB] FAIL oor_release: got held %b want 0", a_held); end
  endtask

  task automatic test_stall_hold();
    a_sel = 2'd2; a_din[95:64] = 32'hAAAA0000; a_stall = 1'b1;
    #3;
    checks++; if (a_out !== 32'hAAAA0000 || a_held !== 1'b0) begin failures++; $display("[TB] FAIL stall_first: got %h/%b want aaaa0000/0", a_out, a_held); end
    @(posedge clock); #1;
    a_din[95:64] = 32'hBBBB0000;
    #3;
    checks++; if (a_out !== 32'hAAAA0000 || a_held !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold1: got %h/%b want aaaa0000/1", a_out, a_held); end
    @(posedge clock); #4;
    checks++; if (a_out !== 32'hAAAA0000 || a_held !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold2: got %h/%b want aaaa0000/1", a_out, a_held); end
    @(posedge clock); #1;
    a_stall = 1'b0;
    #3;
    checks++; if (a_out !== 32'hAAAA0000 || a_held !== 1'b1) begin failures++; $display("[TB] FAIL stall_exit_cycle: got %h/%b want aaaa0000/1", a_out, a_held); end
    @(posedge clock); #4;
    checks++; if (a_out !== 32'hBBBB0000 || a_held !== 1'b0) begin failures++; $display("[TB] FAIL stall_released: got %h/%b want bbbb0000/0", a_out, a_held); end
  endtask

  task automatic test_flush_hold();
    a_sel = 2'd2; a_din[95:64] = 32'hCAFEF00D; a_stall = 1'b1;
    @(posedge clock); #1;
    a_din[95:64] = 32'h0BADBEEF; a_flush = 1'b1;
    #3;
    checks++; if (a_out !== 32'hCAFEF00D || a_held !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre: got %h/%b want cafef00d/1", a_out, a_held); end
    @(posedge clock); #1;
    a_flush = 1'b0;
    #3;
    checks++; if (a_out !== 32'h0BADBEEF || a_held !== 1'b0) begin failures++; $display("[TB] FAIL flush_live: got %h/%b want 0badbeef/0", a_out, a_held); end
    @(posedge clock); #1;
    a_din[95:64] = 32'h77777777; a_stall = 1'b0;
    #3;
    checks++; if (a_out !== 32'h0BADBEEF || a_held !== 1'b1) begin failures++; $display("[TB] FAIL flush_recapture: got %h/%b want 0badbeef/1", a_out, a_held); end
    @(posedge clock); #4;
    checks++; if (a_out !== 32'h77777777 || a_held !== 1'b0) begin failures++; $display("[TB] FAIL flush_after: got %h/%b want 77777777/0", a_out, a_held); end
  endtask

  task automatic test_async_reset();
    a_sel = 2'd1; a_din[63:32] = 32'h12345678; a_stall = 1'b1;
    @(posedge clock); #1;
    a_din[63:32] = 32'h99990000;
    #1;
    checks++; if (a_out !== 32'h12345678 || a_held !== 1'b1) begin failures++; $display("[TB] FAIL areset_hold: got %h/%b want 12345678/1", a_out, a_held); end
    reset_n = 1'b0;
    #1;
    checks++; if (a_out !== 32'h99990000 || a_held !== 1'b0) begin failures++; $display("[TB] FAIL areset_now: got %h/%b want 99990000/0", a_out, a_held); end
    reset_n = 1'b1; a_stall = 1'b0;
    @(posedge clock); #4;
    checks++; if (a_out !== 32'h99990000 || a_held !== 1'b0) begin failures++; $display("[TB] FAIL areset_after: got %h/%b want 99990000/0", a_out, a_held); end
  endtask

  task automatic test_reg_out();
    b_din = {32'hB0B00003, 32'hB0B00002, 32'hB0B00001, 32'hB0B00000};
    b_sel = 2'd0; b_stall = 1'b0; b_flush = 1'b0;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    checks++; if (b_out !== 32'h0 || b_held !== 1'b0) begin failures++; $display("[TB] FAIL regout_first: got %h/%b want 0/0", b_out, b_held); end
    for (int k = 0; k < 4; k++) begin
      b_sel = 2'(k);
      @(posedge clock); #3;
      checks++; if (b_out !== 32'hB0B00000 + 32'(k) || b_held !== 1'b0) begin failures++; $display("[TB] FAIL regout_step%0d: got %h/%b want %h/0", k, b_out, b_held, 32'hB0B00000 + 32'(k)); end
    end
    b_sel = 2'd2; b_stall = 1'b1;
    @(posedge clock); #1;
    b_din[95:64] = 32'hD00D0002;
    #2;
    checks++; if (b_out !== 32'hB0B00002 || b_held !== 1'b0) begin failures++; $display("[TB] FAIL regout_stall_live: got %h/%b want b0b00002/0", b_out, b_held); end
    @(posedge clock); #1;
    b_stall = 1'b0;
    #2;
    checks++; if (b_out !== 32'hB0B00002 || b_held !== 1'b1) begin failures++; $display("[TB] FAIL regout_stall_held1: got %h/%b want b0b00002/1", b_out, b_held); end
    @(posedge clock); #3;
    checks++; if (b_out !== 32'hB0B00002 || b_held !== 1'b1) begin failures++; $display("[TB] FAIL regout_stall_held2: got %h/%b want b0b00002/1", b_out, b_held); end
    @(posedge clock); #1;
    b_flush = 1'b1;
    #2;
    checks++; if (b_out !== 32'hD00D0002 || b_held !== 1'b0) begin failures++; $display("[TB] FAIL regout_released: got %h/%b want d00d0002/0", b_out, b_held); end
    @(posedge clock); #1;
    b_flush = 1'b0;
    #2;
    checks++; if (b_out !== 32'h0 || b_held !== 1'b0) begin failures++; $display("[TB] FAIL regout_flush: got %h/%b want 0/0", b_out, b_held); end
    @(posedge clock); #3;
    checks++; if (b_out !== 32'hD00D0002) begin failures++; $display("[TB] FAIL regout_after_flush: got %h want d00d0002", b_out); end
  endtask

  task automatic test_random_sweep();
    logic [31:0] exp_out, lv, co;
    logic        exp_held, ch;
    r_sel = '0; r_din = '0; r_stall = 1'b0; r_flush = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_hold[i] = 1'b0; m_cap[i] = '0; m_rout[i] = '0; m_rheld[i] = 1'b0;
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r_sel = 4'($urandom);
      for (int j = 0; j < 16; j++) r_din[j*32 +: 32] = $urandom;
      r_stall = ($urandom_range(0, 9) < 5);
      r_flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_hold[i] = 1'b0; m_cap[i] = '0; m_rout[i] = '0; m_rheld[i] = 1'b0;
        end
        #1 reset_n = 1'b1;
      end
      #3;
      for (int i = 0; i < 4; i++) begin
        if (cfg_reg(i)) begin
          exp_out = m_rout[i]; exp_held = m_rheld[i];
        end else begin
          exp_out  = m_hold[i] ? m_cap[i] : ref_live(i, r_sel, r_din);
          exp_held = m_hold[i];
        end
        checks++;
        if (r_out[i] !== exp_out || r_held[i] !== exp_held) begin
          failures++;
          $display("[TB] FAIL random_cfg%0d cycle %0d: got %h/%b want %h/%b", i, cyc, r_out[i], r_held[i], exp_out, exp_held);
        end
      end
      // Advance the model across the coming clock edge
      for (int i = 0; i < 4; i++) begin
        lv = ref_live(i, r_sel, r_din);
        co = m_hold[i] ? m_cap[i] : lv;
        ch = m_hold[i];
        if (r_flush) begin
          m_rout[i] = '0; m_rheld[i] = 1'b0; m_hold[i] = 1'b0; m_cap[i] = '0;
        end else begin
          m_rout[i] = co; m_rheld[i] = ch;
          if (r_stall) begin
            if (!m_hold[i]) m_cap[i] = lv;
            m_hold[i] = 1'b1;
          end else begin
            m_hold[i] = 1'b0;
          end
        end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_stall_hold();
    test_flush_hold();
    test_async_reset();
    test_reg_out();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
